// File: rtl/aes_sifreleme_denetleyici_if.sv
// Plaintext-in, round-key fetch and ciphertext-out handshakes of the AES-128 sequencer.
// slave = the sequencer; master = the plaintext source / key store / ciphertext sink.
interface aes_sifreleme_denetleyici_if #(
  parameter int IDX_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_blok;
  logic             key_req;
  logic [IDX_W-1:0] key_idx;
  logic             key_valid;
  logic [127:0]     key_data;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_blok;
  logic             busy;

  modport slave (
    input  in_valid, in_blok, key_valid, key_data, out_ready,
    output in_ready, key_req, key_idx, out_valid, out_blok, busy
  );

  modport master (
    output in_valid, in_blok, key_valid, key_data, out_ready,
    input  in_ready, key_req, key_idx, out_valid, out_blok, busy
  );
endinterface

// File: rtl/aes_sifreleme_denetleyici.sv
// Iterative AES-128 encryptor: one round per accepted round key; ciphertext NUM_ROUNDS+2 cycles after accept
// with keys always valid. Key stalls freeze the round; ciphertext is held in DONE until out_ready.
module aes_sifreleme_denetleyici #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  aes_sifreleme_denetleyici_if.slave bus
);

  typedef enum logic [1:0] {IDLE, KEYW, DONE} st_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS);

  st_t              st_q, st_d;
  logic [127:0]     state_q, state_d;
  logic [IDX_W-1:0] round_q, round_d;
  logic [127:0]     sb, sr, mc, keyed;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p2, p4, p8, p16, p32, p64, p128, inv;
    p2   = gmul(x, x);
    p4   = gmul(p2, p2);
    p8   = gmul(p4, p4);
    p16  = gmul(p8, p8);
    p32  = gmul(p16, p16);
    p64  = gmul(p32, p32);
    p128 = gmul(p64, p64);
    inv  = gmul(gmul(gmul(p2, p4), gmul(p8, p16)), gmul(gmul(p32, p64), p128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[k*8 +: 8] = sbox(s[k*8 +: 8]);
    return o;
  endfunction

  // Byte k sits at [127-8k -: 8], row k%4, column k/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  assign sb = sub_bytes(state_q);
  assign sr = shift_rows(sb);
  assign mc = mix_columns(sr);

  always_comb begin
    keyed = mc ^ bus.key_data;
    if (round_q == '0)        keyed = state_q ^ bus.key_data;
    else if (round_q == LAST) keyed = sr ^ bus.key_data;
  end

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    round_d = round_q;
    case (st_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.in_blok;
          round_d = '0;
          st_d    = KEYW;
        end
      end
      KEYW: begin
        if (bus.key_valid) begin
          state_d = keyed;
          if (round_q == LAST) st_d = DONE;
          else                 round_d = round_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // in_ready is qualified by rst_n so it stays low while reset is held.
  assign bus.in_ready  = rst_n && (st_q == IDLE);
  assign bus.key_req   = (st_q == KEYW);
  assign bus.key_idx   = (st_q == KEYW) ? round_q : '0;
  assign bus.out_valid = (st_q == DONE);
  assign bus.out_blok  = (st_q == DONE) ? state_q : '0;
  assign bus.busy      = (st_q != IDLE);

endmodule

// File: tb/tb_aes_sifreleme_denetleyici.sv
// Directed bench for the AES-128 sequencer using FIPS-197 vectors; round keys are expanded here
// from a table S-box and served back on the key port.
module tb_aes_sifreleme_denetleyici;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  aes_sifreleme_denetleyici_if #(.IDX_W(4)) bus ();

  aes_sifreleme_denetleyici #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int total = 0;
  int bad   = 0;
  bit kv_rand = 1'b0;
  bit kv_tie  = 1'b0;
  logic [127:0] rk [0:15];

  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  always @(negedge clk) bus.key_valid = kv_rand ? 1'($urandom_range(0, 1)) : kv_tie;
  assign bus.key_data = rk[bus.key_idx];

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_flat[(255 - int'(x))*8 +: 8];
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [127:0] pt);
    int g = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("offer_ready", 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.in_blok  = pt;
  endtask

  // The first edge waited on is the accept edge.
  task automatic collect(input string tag, input logic [127:0] ct, input bit chk_lat, input bit drop);
    int n = 0;
    int exp_idx = 0;
    bit req_prev = 1'b0;
    bit seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1 && drop) bus.in_valid = 1'b0;
      if (req_prev && bus.key_valid) exp_idx++;
      if (bus.key_req) chk({tag, "_idx"}, 128'(bus.key_idx), 128'(exp_idx));
      req_prev = bus.key_req;
      seen = bus.out_valid;
    end
    chk({tag, "_seen"}, 128'(seen), 128'(1));
    if (chk_lat) chk({tag, "_lat"}, 128'(n), 128'(12));
    chk({tag, "_nkeys"}, 128'(exp_idx), 128'(11));
    chk({tag, "_ct"}, bus.out_blok, ct);
    chk({tag, "_busy"}, 128'(bus.busy), 128'(1));
    chk({tag, "_inrdy"}, 128'(bus.in_ready), 128'(0));
  endtask

  task automatic hold_release(input string tag, input logic [127:0] ct, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      bus.in_valid = (k % 2 == 0);
      bus.in_blok  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      chk({tag, "_hold_vld"}, 128'(bus.out_valid), 128'(1));
      chk({tag, "_hold_ct"}, bus.out_blok, ct);
      chk({tag, "_hold_inrdy"}, 128'(bus.in_ready), 128'(0));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_rel_vld"}, 128'(bus.out_valid), 128'(0));
    chk({tag, "_rel_blok"}, bus.out_blok, 128'(0));
    chk({tag, "_rel_inrdy"}, 128'(bus.in_ready), 128'(1));
    chk({tag, "_rel_busy"}, 128'(bus.busy), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.in_valid  = 1'b0;
    bus.in_blok   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    for (int r = 0; r < 16; r++) rk[r] = '0;

    // Reset values, then in_ready once released.
    #7;
    chk("rst_inrdy", 128'(bus.in_ready), 128'(0));
    chk("rst_keyreq", 128'(bus.key_req), 128'(0));
    chk("rst_keyidx", 128'(bus.key_idx), 128'(0));
    chk("rst_outvld", 128'(bus.out_valid), 128'(0));
    chk("rst_outblok", bus.out_blok, 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    #5 rst_n = 1'b1;
    #1 chk("rel_inrdy", 128'(bus.in_ready), 128'(1));

    // App.B with key_valid tied high, also while IDLE and DONE.
    expand(KEY_B);
    kv_tie = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_busy", 128'(bus.busy), 128'(0));
    chk("t6_idle_keyreq", 128'(bus.key_req), 128'(0));
    chk("t6_idle_blok", bus.out_blok, 128'(0));
    offer(PT_B);
    collect("t1", CT_B, 1'b1, 1'b1);
    hold_release("t3", CT_B, 5);

    // C.1 with random key stalls.
    expand(KEY_C);
    kv_tie  = 1'b0;
    kv_rand = 1'b1;
    offer(PT_C);
    collect("t2", CT_C, 1'b0, 1'b1);
    hold_release("t2", CT_C, 0);

    // Reset in the middle of an operation.
    kv_rand = 1'b0;
    kv_tie  = 1'b1;
    expand(KEY_B);
    offer(PT_B);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    g = 0;
    while (bus.key_idx !== 4'd5 && g < 30) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("t4_idx5", 128'(bus.key_idx), 128'(5));
    #1 rst_n = 1'b0;
    #1;
    chk("t4_inrdy", 128'(bus.in_ready), 128'(0));
    chk("t4_keyreq", 128'(bus.key_req), 128'(0));
    chk("t4_keyidx", 128'(bus.key_idx), 128'(0));
    chk("t4_outvld", 128'(bus.out_valid), 128'(0));
    chk("t4_outblok", bus.out_blok, 128'(0));
    chk("t4_busy", 128'(bus.busy), 128'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("t4_rel_inrdy", 128'(bus.in_ready), 128'(1));
    offer(PT_B);
    collect("t4b", CT_B, 1'b1, 1'b1);
    hold_release("t4b", CT_B, 0);

    // Back-to-back with in_valid held and out_ready high.
    bus.out_ready = 1'b1;
    offer(PT_B);
    collect("t5a", CT_B, 1'b1, 1'b0);
    @(negedge clk);
    expand(KEY_C);
    bus.in_blok = PT_C;
    @(posedge clk);
    #1;
    chk("t5_idle_vld", 128'(bus.out_valid), 128'(0));
    chk("t5_idle_inrdy", 128'(bus.in_ready), 128'(1));
    chk("t5_idle_busy", 128'(bus.busy), 128'(0));
    collect("t5b", CT_C, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("t5_end_vld", 128'(bus.out_valid), 128'(0));
    chk("t5_end_inrdy", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
